// File: rtl/joystick_genesis_reader.sv
// Mega Drive / Genesis 3- or 6-button pad scanner: one Select sequence per frame, started by the v_sync falling edge.
// Optional JOYSTICK_DEBOUNCE_EN: Saidas only follows a candidate vector that two consecutive scans agree on.
module joystick_genesis_reader #(
    parameter int PHASE_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        Clock50,
    input  logic        Reset,
    input  logic        v_sync,
    input  logic        Pino1,
    input  logic        Pino2,
    input  logic        Pino3,
    input  logic        Pino4,
    input  logic        Pino6,
    input  logic        Pino9,
    output logic        Select,
    output logic [11:0] Saidas,
    output logic        SeisBotoes,
    output logic        Conectado,
    output logic        Valido
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(PHASE_CYCLES - 1);

    logic [5:0]       pin_meta;
    logic [5:0]       pin_sync;
    logic [5:0]       pressed;
    logic             vs_meta;
    logic             vs_sync;
    logic             vs_prev;
    logic             vs_fall;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic [2:0]       phase;
    logic [2:0]       phase_nx;
    logic             select_nx;
    logic             sample;
    logic             commit;

    logic [3:0]       cap_dir;
    logic             cap_a;
    logic             cap_b;
    logic             cap_c;
    logic             cap_start;
    logic             cap_present;
    logic             cap_six;
    logic [3:0]       cap_ext;
    logic [11:0]      candidate;

    // Synchronizers idle high (pins released, v_sync inactive) so reset release never fakes an edge.
    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            pin_meta <= '1;
            pin_sync <= '1;
            vs_meta  <= 1'b1;
            vs_sync  <= 1'b1;
            vs_prev  <= 1'b1;
        end else begin
            pin_meta <= {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1};
            pin_sync <= pin_meta;
            vs_meta  <= v_sync;
            vs_sync  <= vs_meta;
            vs_prev  <= vs_sync;
        end
    end

    assign pressed = ~pin_sync;
    assign vs_fall = vs_prev & ~vs_sync;

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            timer  <= '0;
            phase  <= '0;
            Select <= 1'b1;
        end else begin
            state  <= state_nx;
            timer  <= timer_nx;
            phase  <= phase_nx;
            Select <= select_nx;
        end
    end

    // Select is registered from the next phase so it changes on the same edge the phase does.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        phase_nx = phase;
        sample   = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (vs_fall) begin
                    state_nx = SCAN;
                    timer_nx = '0;
                    phase_nx = '0;
                end
            end
            SCAN: begin
                if (timer == LAST_TICK) begin
                    sample   = 1'b1;
                    timer_nx = '0;
                    if (phase == 3'd7) begin
                        state_nx = COMMIT;
                    end else begin
                        phase_nx = phase + 3'd1;
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
                phase_nx = '0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        select_nx = (state_nx == SCAN) ? ~phase_nx[0] : 1'b1;
    end

    // pressed bit order: [0]Pino1 [1]Pino2 [2]Pino3 [3]Pino4 [4]Pino6 [5]Pino9
    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            cap_dir     <= '0;
            cap_a       <= 1'b0;
            cap_b       <= 1'b0;
            cap_c       <= 1'b0;
            cap_start   <= 1'b0;
            cap_present <= 1'b0;
            cap_six     <= 1'b0;
            cap_ext     <= '0;
        end else if (sample) begin
            case (phase)
                3'd0: begin
                    cap_dir <= pressed[3:0];
                    cap_b   <= pressed[4];
                    cap_c   <= pressed[5];
                end
                3'd1: begin
                    cap_a       <= pressed[4];
                    cap_start   <= pressed[5];
                    cap_present <= pressed[2] & pressed[3];
                end
                3'd5: cap_six <= &pressed[3:0];
                3'd6: cap_ext <= pressed[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        candidate = '0;
        if (cap_present) begin
            candidate[3:0] = cap_dir;
            candidate[4]   = cap_a;
            candidate[5]   = cap_b;
            candidate[6]   = cap_c;
            candidate[7]   = cap_start;
            if (cap_six) begin
                candidate[8]  = cap_ext[2];
                candidate[9]  = cap_ext[1];
                candidate[10] = cap_ext[0];
                candidate[11] = cap_ext[3];
            end
        end
    end

`ifdef JOYSTICK_DEBOUNCE_EN
    logic [11:0] prev_candidate;

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            prev_candidate <= '0;
        end else if (commit) begin
            prev_candidate <= candidate;
        end
    end
`endif

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            Saidas     <= '0;
            SeisBotoes <= 1'b0;
            Conectado  <= 1'b0;
            Valido     <= 1'b0;
        end else begin
            Valido <= commit;
            if (commit) begin
                Conectado  <= cap_present;
                SeisBotoes <= cap_present & cap_six;
`ifdef JOYSTICK_DEBOUNCE_EN
                if (!cap_present) begin
                    Saidas <= '0;
                end else if (candidate == prev_candidate) begin
                    Saidas <= candidate;
                end
`else
                Saidas <= candidate;
`endif
            end
        end
    end

endmodule
